// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: size/error encodings and FSM states shared by the MEM-stage load/store unit.
package mips_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_SIZE = 2'b11;
  typedef enum logic [2:0] {IDLE, RD, LD_FIN, MERGE, WR, RESP} state_t;
endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: big-endian lane extraction/extension for loads and lane merge for sub-word stores.
module byte_lane_unit
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] rdata,
  output logic [31:0] merged
);
  logic [4:0] sh;
  logic [15:0] lane;
  logic [31:0] mask;
  // Byte k sits at bit 8*(3-k); half offset 0 at bit 16, offset 2 at bit 0.
  always_comb begin
    sh = size == SZ_HALF ? {~offset[1], 4'b0000} : {~offset, 3'b000};
    mask = size == SZ_HALF ? 32'h0000_ffff : 32'h0000_00ff;
    lane = 16'(word >> sh);
    rdata = size == SZ_WORD ? word
          : size == SZ_HALF ? {{16{~zext & lane[15]}}, lane}
          : {{24{~zext & lane[7]}}, lane[7:0]};
    merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer driving a word-wide big-endian data memory.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE = 4096,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  state_t state, next;
  logic r_store, r_zext;
  logic [1:0] r_size, err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] wword, ld_data, merged;
  byte_lane_unit lanes (
    .word(mem_rdata), .wdata(wword), .offset(r_addr[1:0]), .size(r_size),
    .zext(r_zext), .rdata(ld_data), .merged(merged)
  );
  always_comb
    err = req_size == 2'b11 ? ERR_SIZE
        : (req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ? ERR_MISALIGN
        : req_addr > 32'(MEM_SIZE - 4) ? ERR_RANGE
        : ERR_NONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = !req_valid || err != ERR_NONE ? IDLE : req_store && req_size == SZ_WORD ? WR : RD;
      RD: next = r_store ? MERGE : LD_FIN;
      MERGE: next = WR;
      default: next = IDLE;
    endcase
  end
  // Memory controls come only from registers so they hold steady through the negedge write.
  always_comb begin
    req_ready = state == IDLE;
    mem_re = state == RD;
    mem_we = state == WR;
    mem_addr = state == RD || state == WR ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    mem_wdata = state == WR ? wword : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_store <= 1'b0;
      r_zext <= 1'b0;
      r_size <= SZ_BYTE;
      r_addr <= '0;
      wword <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= ERR_NONE;
    end else begin
      resp_valid <= 1'b0;
      if (state == IDLE && req_valid) begin
        r_store <= req_store;
        r_zext <= req_unsigned;
        r_size <= req_size;
        r_addr <= req_addr[ADDR_WIDTH-1:0];
        wword <= req_wdata;
        if (err != ERR_NONE) begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err <= err;
        end
      end
      if (state == LD_FIN) begin
        resp_valid <= 1'b1;
        resp_rdata <= ld_data;
        resp_err <= ERR_NONE;
      end
      if (state == MERGE) wword <= merged;
      if (state == WR) begin
        resp_valid <= 1'b1;
        resp_rdata <= '0;
        resp_err <= ERR_NONE;
      end
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store unit placed directly upstream of the word-wide, big-endian, byte-addressed data memory. It accepts one load or store request at a time from the EX/MEM pipeline register and drives the memory's addr/re/we/write_data ports. Sub-word stores (SB/SH) are performed as read-modify-write. Load results are extracted and sign- or zero-extended before being returned to the writeback path, together with alignment, range and size error reporting.

Parameters:
DATA_WIDTH, 32, data word width; only 32 is supported.
MEM_SIZE, 4096, data memory size in bytes; must match the memory instance.
ADDR_WIDTH, $clog2(MEM_SIZE), width of the memory address port.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit idle; a request is accepted when req_valid && req_ready
req_store  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend load (LBU/LHU); ignored for stores and words
req_addr  in  32  byte address from ALU
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal size
mem_addr  out  ADDR_WIDTH  to memory addr; always word-aligned (bits [1:0] = 0)
mem_re  out  1  to memory re
mem_we  out  1  to memory we
mem_wdata  out  32  to memory write_data
mem_rdata  in  32  from memory read_data; valid the cycle after mem_re

Behaviour:
- Reset: state = IDLE. req_ready=1. resp_valid=0, resp_rdata=0, resp_err=0. mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset is asynchronous. Asserting it mid-operation aborts the operation, and mem_we drops immediately, so no partial write occurs.
- mem_* outputs are decoded from registered state and registered request fields only. They must be stable across the negedge, because the memory writes on the negedge.
- States:
  - IDLE
  - RD: mem_re=1.
  - LD_FIN: extract from mem_rdata.
  - MERGE: latch the merged word.
  - WR: mem_we=1.
  - RESP
- Error checks on acceptance, highest priority first:
  - size==11 gives err 11.
  - half with addr[0]!=0, or word with addr[1:0]!=0, gives err 01.
  - addr > MEM_SIZE-4 gives err 10.
  - On any error: no memory access; resp_valid=1 with the error code in cycle T+1; then back to IDLE.
- Latencies, with acceptance at T0 and the response pulse at the cycle listed:
  - Load: RD T1, LD_FIN T2, resp T3.
  - SW: WR T1, resp T2.
  - SB/SH: RD T1, MERGE T2, WR T3, resp T4.
- req_ready=1 only in IDLE, including the IDLE cycle that carries a resp_valid pulse. Back-to-back requests are therefore allowed the cycle after resp_valid.
- Byte lanes are big-endian. Offset k = addr[1:0].
  - Byte k occupies bits [31-8k : 24-8k].
  - Half offset 0 occupies [31:16]; half offset 2 occupies [15:0].
- Loads:
  - Sign-extend from the lane MSB unless req_unsigned is set.
  - Word loads pass mem_rdata through unchanged.
- Stores:
  - The merged word is the read word with only the target lane replaced by req_wdata[7:0] (byte) or req_wdata[15:0] (half).
  - For SW, mem_wdata = req_wdata.
- The request is latched on acceptance. Changes on req_* while busy are ignored.
- Only req_addr[ADDR_WIDTH-1:0] reaches the memory. Upper bits are used solely for the range check.

Decomposition:
- Package mips_mem_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - error codes (ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_SIZE);
  - the state enum.
- Sub-module byte_lane_unit is combinational and does both jobs below:
  - load extraction/extension from (word, offset, size, unsigned);
  - store merge from (old word, new data, offset, size).

Test Plan:
1. SW 0xDEADBEEF @0x010, then LW @0x010 -> resp_rdata 0xDEADBEEF, err 00. SW resp at T+2, LW resp at T+3. mem_we high for exactly one cycle.
2. After 1: SB 0x000000AA @0x011 -> LW @0x010 = 0xDEAABEEF. LB @0x011 = 0xFFFFFFAA. LBU @0x011 = 0x000000AA. SB resp at T+4.
3. After 2: SH 0x00001234 @0x012 -> LW @0x010 = 0xDEAA1234. LH @0x012 = 0x00001234. LH @0x010 = 0xFFFFDEAA. LHU @0x010 = 0x0000DEAA.
4. Errors:
   - LW @0x013 -> err 01.
   - LH @0x011 -> err 01.
   - SW @0x1000 -> err 10.
   - size=11 @0x01D -> err 11, not err 01.
   - Each error responds at T+1 with mem_re=mem_we=0 throughout.
   - SW @0xFFC succeeds.
5. Assert rst during MERGE of an SB @0x011 -> all outputs 0 immediately, mem_we never pulses, and after rst release req_ready=1.
6. Back-to-back: SW, LW and SB issued on the cycle after each prior resp_valid -> correct data, no lost requests. A req_addr change while busy has no effect.
